// File: rtl/div_sequencer_pkg.sv
// div_sequencer_pkg: divide opcodes, FSM state encoding and special-case constants for div_sequencer.
package div_sequencer_pkg;
  localparam logic [4:0] OP_DIV  = 5'h0c;
  localparam logic [4:0] OP_DIVU = 5'h0d;
  localparam logic [4:0] OP_REM  = 5'h0e;
  localparam logic [4:0] OP_REMU = 5'h0f;
  localparam logic [31:0] DIV_OVF_DIVIDEND  = 32'h8000_0000;
  localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hffff_ffff;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
  function automatic logic is_div_op(input logic [4:0] op);
    return op == OP_DIV || op == OP_DIVU || op == OP_REM || op == OP_REMU;
  endfunction
  function automatic logic is_signed_op(input logic [4:0] op);
    return op == OP_DIV || op == OP_REM;
  endfunction
endpackage

// File: rtl/div_sequencer_div_step.sv
// div_sequencer_div_step: one combinational restoring-division step (shift in, trial subtract, quotient bit).
module div_sequencer_div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_in,
  input  logic         dividend_bit,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic         q_bit
);
  logic [W:0] diff;
  logic       borrow;
  // one extra bit on top of the W+1 remainder makes the borrow explicit
  assign {borrow, diff} = {rem_in, dividend_bit} - {2'b00, divisor};
  assign q_bit = ~borrow;
  assign rem_out = borrow ? {rem_in[W-1:0], dividend_bit} : diff;
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: iterative restoring DIV/DIVU/REM/REMU sequencer with BUSY stall and one-cycle VALID.
// Define DIV_EARLY_TERM_EN to finish in one edge when |dividend| < |divisor|.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int STEPS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      opcode,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic            flush,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] OVF = XLEN'(DIV_OVF_DIVIDEND);
  state_t state, state_n;
  logic [XLEN:0] rem;
  logic [XLEN-1:0] quo, dsr, mag1, mag2;
  logic [CW-1:0] cnt;
  logic is_rem, neg_q, neg_r, fast;
  logic sgn, s1, s2, div0, ovf, early, fast_c, accept;
  logic [XLEN:0] r_ch [STEPS+1];
  logic [XLEN-1:0] q_ch [STEPS+1];
  logic [STEPS-1:0] qb;
  assign sgn = is_signed_op(opcode);
  assign s1 = sgn & data1[XLEN-1];
  assign s2 = sgn & data2[XLEN-1];
  assign mag1 = s1 ? -data1 : data1;
  assign mag2 = s2 ? -data2 : data2;
  assign div0 = data2 == '0;
  assign ovf = sgn && data1 == OVF && data2 == '1;
`ifdef DIV_EARLY_TERM_EN
  assign early = !div0 && mag1 < mag2;
`else
  assign early = 1'b0;
`endif
  // short-path operations resolve their final quotient/remainder at acceptance
  assign fast_c = div0 | ovf | early;
  assign accept = (state == IDLE || state == DONE) && start && is_div_op(opcode) && !flush;
  always_comb begin
    state_n = flush ? IDLE :
              accept ? (fast_c ? FIX : CALC) :
              state == CALC ? (cnt == CW'(XLEN - STEPS) ? FIX : CALC) :
              state == FIX ? DONE : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  assign r_ch[0] = rem;
  assign q_ch[0] = quo;
  for (genvar i = 0; i < STEPS; i++) begin : g_step
    div_sequencer_div_step #(.W(XLEN)) u_step (
      .rem_in       (r_ch[i]),
      .dividend_bit (q_ch[i][XLEN-1]),
      .divisor      (dsr),
      .rem_out      (r_ch[i+1]),
      .q_bit        (qb[i])
    );
    assign q_ch[i+1] = {q_ch[i][XLEN-2:0], qb[i]};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem <= '0;
      quo <= '0;
      dsr <= '0;
      cnt <= '0;
      is_rem <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      fast <= 1'b0;
      result <= '0;
    end else if (accept) begin
      is_rem <= opcode == OP_REM || opcode == OP_REMU;
      neg_q <= !fast_c && (s1 ^ s2);
      neg_r <= !fast_c && s1;
      fast <= fast_c;
      dsr <= mag2;
      cnt <= '0;
      quo <= div0 ? XLEN'(DIV_ZERO_QUOTIENT) : ovf ? OVF : early ? '0 : mag1;
      rem <= (div0 || early) ? {1'b0, data1} : '0;
    end else if (state == CALC && !flush) begin
      rem <= r_ch[STEPS];
      quo <= q_ch[STEPS];
      cnt <= cnt + CW'(STEPS);
    end else if (state == FIX && !flush) begin
      result <= is_rem ? (neg_r ? -rem[XLEN-1:0] : rem[XLEN-1:0]) : (neg_q ? -quo : quo);
    end
  end
  assign busy = state == CALC || (state == FIX && !fast);
  assign valid = state == DONE && !flush;
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed and random checks of div_sequencer against an arithmetic reference model.
module tb_div_sequencer;
  import div_sequencer_pkg::*;
  logic clk = 1'b0;
  logic reset, start, flush, busy, valid;
  logic [4:0] opcode;
  logic [31:0] data1, data2, result, last_res;
  int checks = 0;
  int fails = 0;
  div_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .opcode (opcode),
    .data1  (data1),
    .data2  (data2),
    .flush  (flush),
    .busy   (busy),
    .valid  (valid),
    .result (result)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                        output int lat);
    logic sg;
    logic [31:0] q, r;
    sg = op == OP_DIV || op == OP_REM;
    if (b == 0) begin
      q = 32'hffff_ffff;
      r = a;
      lat = 1;
    end else if (sg && a == 32'h8000_0000 && b == 32'hffff_ffff) begin
      q = 32'h8000_0000;
      r = 0;
      lat = 1;
    end else begin
      if (sg) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
      lat = 33;
`ifdef DIV_EARLY_TERM_EN
      if (((sg && a[31]) ? -a : a) < ((sg && b[31]) ? -b : b)) lat = 1;
`endif
    end
    return (op == OP_REM || op == OP_REMU) ? r : q;
  endfunction
  task automatic op_go(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    opcode = op;
    data1 = a;
    data2 = b;
  endtask
  task automatic op_wait(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat, exp_lat, busy_n;
    logic [31:0] exp;
    exp = model(op, a, b, exp_lat);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_n = 0;
    while (!valid && lat < 40) begin
      busy_n += busy ? 1 : 0;
      @(posedge clk); #1;
      lat++;
    end
    chk("valid", 32'(valid), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("result", result, exp);
    chk("busy_cycles", 32'(busy_n), exp_lat == 1 ? 32'd0 : 32'(exp_lat));
    last_res = exp;
  endtask
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    op_go(op, a, b);
    op_wait(op, a, b);
    @(posedge clk); #1;
    chk("valid_pulse", 32'(valid), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask
  initial begin
    logic [4:0] ops [4];
    logic [4:0] op;
    logic [31:0] a, b;
    ops = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    opcode = '0;
    data1 = '0;
    data2 = '0;
    last_res = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_result", result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_op(OP_DIVU, 100, 7);
    run_op(OP_REMU, 100, 7);
    run_op(OP_DIV, 32'hffff_ff9c, 7);
    run_op(OP_REM, 32'hffff_ff9c, 7);
    run_op(OP_REM, 100, 32'hffff_fff9);
    run_op(OP_DIV, 5, 0);
    run_op(OP_REMU, 5, 0);
    run_op(OP_DIV, 32'h8000_0000, 32'hffff_ffff);
    run_op(OP_REM, 32'h8000_0000, 32'hffff_ffff);
    run_op(OP_DIVU, 3, 10);
    run_op(OP_REM, 32'hffff_fffd, 10);
    // non-divide opcode must be ignored
    op_go(5'h00, 40, 2);
    repeat (3) begin
      @(posedge clk); #1;
      chk("nondiv_busy", 32'(busy), 32'd0);
      chk("nondiv_valid", 32'(valid), 32'd0);
    end
    start = 1'b0;
    // flush mid-CALC keeps the previous result
    op_go(OP_DIVU, 1000, 3);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_valid", 32'(valid), 32'd0);
    chk("flush_result", result, last_res);
    run_op(OP_DIVU, 1000, 3);
    // flush in DONE beats VALID and a simultaneous START
    op_go(OP_DIV, 5, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    op_go(OP_DIVU, 100, 7);
    #1;
    chk("done_flush_valid", 32'(valid), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    start = 1'b0;
    chk("done_flush_busy", 32'(busy), 32'd0);
    chk("done_flush_result", result, 32'hffff_ffff);
    @(posedge clk); #1;
    chk("done_flush_noacc", 32'(busy | valid), 32'd0);
    // back-to-back start in the DONE cycle
    op_go(OP_DIVU, 9, 3);
    op_wait(OP_DIVU, 9, 3);
    op_go(OP_REMU, 9, 4);
    op_wait(OP_REMU, 9, 4);
    @(posedge clk); #1;
    chk("b2b_pulse", 32'(valid), 32'd0);
    for (int k = 0; k < 24; k++) begin
      op = ops[$urandom_range(0, 3)];
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom_range(0, 15);
        1: b = $urandom;
        2: b = -$urandom_range(1, 20);
        default: b = a >> $urandom_range(0, 31);
      endcase
      run_op(op, a, b);
    end
    // asynchronous reset mid-CALC
    op_go(OP_DIVU, 1000, 3);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_result", result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_op(OP_REMU, 1000, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Iterative radix-2 restoring divider and sequencer for the M-extension DIV/DIVU/REM/REMU operations.
- Sits beside the combinational EX-stage ALU and replaces its single-cycle divide path.
- Accepts one operation per START handshake and holds BUSY so the hazard unit stalls the pipeline.
- Returns a registered RESULT with a one-cycle VALID pulse.

Parameters:
- XLEN, 32, operand/result width.
- STEPS, 1, quotient bits retired per CALC cycle; legal values 1, 2, 4; must divide XLEN.

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  request; sampled only in IDLE or DONE.
- OPCODE  in  5  ALU opcode (`DIV, `DIVU, `REM, `REMU); captured with START.
- DATA1  in  XLEN  dividend; captured with START.
- DATA2  in  XLEN  divisor; captured with START.
- FLUSH  in  1  synchronous abort from branch/exception logic.
- BUSY  out  1  operation in flight; stall request to the pipeline.
- VALID  out  1  one-cycle pulse; RESULT is valid.
- RESULT  out  XLEN  quotient or remainder; held until the next accepted START.

Behaviour:
- Reset: asynchronous, active-high.
  - State=IDLE; BUSY=0; VALID=0; RESULT=0; all internal registers cleared.
  - Reset asserted mid-operation discards the operation; no VALID is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE, START=1 with a divide-class OPCODE (acceptance):
  - Capture OPCODE.
  - Capture |DATA1| and |DATA2| (signed ops) or raw values (unsigned ops).
  - Capture the dividend sign and the quotient sign (sign1^sign2).
  - Clear the partial remainder; counter=0.
- Special cases, checked at acceptance; each goes directly to FIX, skipping CALC:
  - DATA2==0: quotient=all ones, remainder=DATA1, for signed and unsigned ops.
  - Signed overflow, DATA1=0x80000000 with DATA2=0xFFFFFFFF: quotient=0x80000000, remainder=0.
- Normal acceptance: go to CALC.
- START with any non-divide OPCODE: ignored; state unchanged; no BUSY, no VALID.
- CALC:
  - Each cycle: STEPS restoring steps (shift remainder in, trial subtract, set quotient bit); counter+=STEPS.
  - Advance to FIX when counter reaches XLEN-STEPS.
- FIX:
  - Apply sign: negate quotient if quotient sign is set; negate remainder if dividend sign is set (signed ops only; special cases bypass correction).
  - Load RESULT with the quotient (DIV/DIVU) or the remainder (REM/REMU); go to DONE.
- DONE:
  - VALID=1 for exactly this cycle.
  - START in this cycle is accepted as in IDLE (back-to-back ops); otherwise go to IDLE.
- BUSY=1 in CALC and FIX.
- Latency, from the clock edge that samples START to the edge that sets VALID:
  - Normal: XLEN/STEPS+1 edges (33 for defaults).
  - Special cases: 1 edge.
- Unsigned arithmetic: the remainder register is XLEN+1 bits so the trial-subtract borrow is explicit; no wrap-around.
- FLUSH:
  - Any state goes to IDLE next edge; BUSY drops; no VALID; RESULT unchanged.
  - FLUSH has priority over a simultaneous START and over the VALID of that cycle.

Optional Feature:
- Macro: DIV_EARLY_TERM_EN.
- Defined: at acceptance, if |dividend| < |divisor| (unsigned compare of captured magnitudes, divisor non-zero), skip CALC. Quotient=0, remainder=dividend, sign correction still applied in FIX; latency 1 edge.
- Undefined: such operands take the full CALC sequence; results are identical, only latency differs.

Decomposition:
- Shared package/defines: divide opcode encodings (same values the ALU decodes), the 2-bit state encoding, DIV_OVF_DIVIDEND (0x80000000) and DIV_ZERO_QUOTIENT (all ones).
- One natural sub-module: div_step.
  - Combinational single restoring step: remainder_in, dividend_bit, divisor -> remainder_out, q_bit.
  - Instantiated STEPS times in a chain inside CALC.

Test Plan:
- DIVU 100 / 7 -> VALID 33 edges after START, RESULT=14. REMU same operands -> RESULT=2; BUSY high for the 32 CALC cycles plus FIX.
- DIV 0xFFFFFF9C (-100) / 7 -> 0xFFFFFFF2 (-14). REM -100 / 7 -> 0xFFFFFFFE (-2). REM 100 / -7 -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0. All four: VALID 1 edge after START, BUSY never rises.
- FLUSH asserted 10 cycles into DIVU 1000/3 -> IDLE next edge, no VALID, RESULT retains prior value. New START accepted the following cycle completes normally (1000/3=333).
- START asserted during the DONE cycle of DIVU 9/3 with REMU 9/4 -> first VALID RESULT=3; second VALID 33 edges later RESULT=1. RESET pulse mid-CALC -> all outputs 0 immediately.
- With DIV_EARLY_TERM_EN: DIVU 3/10 -> RESULT=0 after 1 edge; REM -3/10 -> 0xFFFFFFFD after 1 edge. Without the macro, the same ops give the same values after 33 edges.
